// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side handshakes around mem_port_arbiter.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [DW-1:0]   i_rdata;
    logic            i_err;

    logic            d_req;
    logic            d_we;
    logic [DW/8-1:0] d_be;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;
    logic            d_err;

    logic            m_req;
    logic            m_we;
    logic [DW/8-1:0] m_be;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic            m_ack;
    logic [DW-1:0]   m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_ack, m_rdata,
        output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
               m_req, m_we, m_be, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_ack, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
               m_req, m_we, m_be, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch (IF)
// and load/store (DM), with a per-access watchdog that turns a missing m_ack into an error.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    mem_port_arbiter_if.slave    bus,
    output logic                 busy
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIM = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

    state_t          r_state;
    logic            r_last_dm;
    logic            r_owner_dm;
    logic            r_we;
    logic [DW/8-1:0] r_be;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic            r_err;
    logic [CW-1:0]   r_cnt;
    logic            r_m_req;
    logic            r_i_rvalid;
    logic            r_d_rvalid;
    logic            r_busy;

    logic            w_idle;
    logic            w_i_win;
    logic            w_d_win;
    logic            w_expire;

    // Grants are gated by RSTn so they fall with reset, not at the next clock.
    always_comb begin
        w_idle   = RSTn && (r_state == S_IDLE);
        w_i_win  = w_idle && bus.i_req && (!bus.d_req || r_last_dm);
        w_d_win  = w_idle && bus.d_req && (!bus.i_req || !r_last_dm);
        w_expire = (TIMEOUT != 0) && !bus.m_ack && (r_cnt == LIM);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= S_IDLE;
            r_last_dm  <= 1'b1;
            r_owner_dm <= 1'b0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_m_req    <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_i_win || w_d_win) begin
                        r_state    <= S_ISSUE;
                        r_m_req    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_owner_dm <= w_d_win;
                        r_last_dm  <= w_d_win;
                        r_err      <= 1'b0;
                        r_rdata    <= '0;
                        if (w_d_win) begin
                            r_we    <= bus.d_we;
                            r_be    <= bus.d_be;
                            r_addr  <= bus.d_addr;
                            r_wdata <= bus.d_wdata;
                        end else begin
                            r_we    <= 1'b0;
                            r_be    <= '1;
                            r_addr  <= bus.i_addr;
                            r_wdata <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    // An ack in the expiry cycle wins over the watchdog.
                    if (bus.m_ack) begin
                        r_state    <= S_RESP;
                        r_m_req    <= 1'b0;
                        r_rdata    <= r_we ? '0 : bus.m_rdata;
                        r_err      <= 1'b0;
                        r_i_rvalid <= !r_owner_dm;
                        r_d_rvalid <= r_owner_dm;
                    end else if (w_expire) begin
                        r_state    <= S_RESP;
                        r_m_req    <= 1'b0;
                        r_rdata    <= '0;
                        r_err      <= 1'b1;
                        r_i_rvalid <= !r_owner_dm;
                        r_d_rvalid <= r_owner_dm;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_m_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.i_gnt    = w_i_win;
    assign bus.d_gnt    = w_d_win;
    assign bus.i_rvalid = r_i_rvalid;
    assign bus.d_rvalid = r_d_rvalid;
    assign bus.i_rdata  = r_rdata;
    assign bus.d_rdata  = r_rdata;
    assign bus.i_err    = r_err;
    assign bus.d_err    = r_err;
    assign bus.m_req    = r_m_req;
    assign bus.m_we     = r_we;
    assign bus.m_be     = r_be;
    assign bus.m_addr   = r_addr;
    assign bus.m_wdata  = r_wdata;
    assign busy         = r_busy;
endmodule
